decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 52 +++++
 rtl/decode_stage_imm_gen.sv | 36 +++
 rtl/decode_stage.sv | 145 ++++++++++++++
 tb/tb_decode_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared defines for the decode stage: format codes, RISC-V major opcodes,
// skid-buffer states and the opcode-to-format lookup.
package decode_stage_pkg;

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_UNDEF = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [6:0] OP_LOAD     = 7'd3;
    localparam logic [6:0] OP_MISC_MEM = 7'd15;
    localparam logic [6:0] OP_IMM      = 7'd19;
    localparam logic [6:0] OP_AUIPC    = 7'd23;
    localparam logic [6:0] OP_IMM_32   = 7'd27;
    localparam logic [6:0] OP_STORE    = 7'd35;
    localparam logic [6:0] OP_REG      = 7'd51;
    localparam logic [6:0] OP_LUI      = 7'd55;
    localparam logic [6:0] OP_REG_32   = 7'd59;
    localparam logic [6:0] OP_BRANCH   = 7'd99;
    localparam logic [6:0] OP_JALR     = 7'd103;
    localparam logic [6:0] OP_JAL      = 7'd111;
    localparam logic [6:0] OP_SYSTEM   = 7'd115;

    // Word-sized opcodes only exist on RV64; on RV32 they are undecodable.
    function automatic fmt_e opcode_format(input logic [6:0] opcode, input logic rv64);
        fmt_e fmt;
        case (opcode)
            OP_LOAD, OP_MISC_MEM, OP_IMM, OP_JALR, OP_SYSTEM: fmt = FMT_I;
            OP_AUIPC, OP_LUI:                                 fmt = FMT_U;
            OP_STORE:                                         fmt = FMT_S;
            OP_REG:                                           fmt = FMT_R;
            OP_BRANCH:                                        fmt = FMT_B;
            OP_JAL:                                           fmt = FMT_J;
            OP_IMM_32:                                        fmt = rv64 ? FMT_I : FMT_UNDEF;
            OP_REG_32:                                        fmt = rv64 ? FMT_R : FMT_UNDEF;
            default:                                          fmt = FMT_UNDEF;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: assembles the format-specific immediate and
// sign-extends it (sign bit is always inst[31]) to XLEN.
module imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  fmt_e            format,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    // The opcode bits carry no immediate data in any format.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^inst[6:0];

    // Build the 32-bit sign-extended immediate for the decoded format.
    always_comb begin
        // NOTE: default first so every path assigns imm32 and no latch is inferred.
        imm32 = '0;
        case (format)
            FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm32 = {inst[31:12], 12'b0};
            FMT_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast replicates bit 31 up to XLEN.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes the incoming word combinationally and
// holds results in a two-entry skid buffer (main + skid) so in_ready is a
// pure function of registered state.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_format,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc
);

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        fmt_e            fmt;
        logic [XLEN-1:0] imm;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } entry_t;

    localparam entry_t ENTRY_RST = '{fmt: FMT_UNDEF, default: '0};

    state_e          state_q, state_d;
    entry_t          main_q, main_d;
    entry_t          skid_q, skid_d;
    entry_t          dec_entry;
    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            accept;
    logic            drain;

    assign dec_fmt = opcode_format(in_inst[6:0], XLEN == 64);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst   (in_inst),
        .format (dec_fmt),
        .imm    (dec_imm)
    );

    // Decode the incoming word into a full entry ahead of the buffer.
    always_comb begin
        dec_entry.opcode  = in_inst[6:0];
        dec_entry.func3   = in_inst[14:12];
        dec_entry.func7   = in_inst[31:25];
        dec_entry.rd      = in_inst[11:7];
        dec_entry.rs1     = in_inst[19:15];
        dec_entry.rs2     = in_inst[24:20];
        dec_entry.fmt     = dec_fmt;
        dec_entry.imm     = dec_imm;
        dec_entry.illegal = (dec_fmt == FMT_UNDEF) || (in_inst[1:0] != 2'b11);
        dec_entry.pc      = in_pc;
    end

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Skid-buffer next state; flush wins over any accept or drain.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = dec_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        skid_d  = dec_entry;
                        state_d = ST_FULL;
                    end else if (!accept && drain) begin
                        state_d = ST_EMPTY;
                    end else if (accept && drain) begin
                        main_d  = dec_entry;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: entries are reset too because out_* come straight from main_q
            // and must read as zero / UNDEF while the buffer is empty after reset.
            state_q <= ST_EMPTY;
            main_q  <= ENTRY_RST;
            skid_q  <= ENTRY_RST;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_opcode  = main_q.opcode;
    assign out_func3   = main_q.func3;
    assign out_func7   = main_q.func7;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_format  = main_q.fmt;
    assign out_imm     = main_q.imm;
    assign out_illegal = main_q.illegal;
    assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32 and an RV64 instance share the
// same stimulus; expected decodes are queued on acceptance and checked by
// per-instance monitors whenever an entry is presented.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] inst;
        logic [2:0]  fmt32;
        logic [31:0] imm32;
        logic        ill32;
        logic [2:0]  fmt64;
        logic [63:0] imm64;
        logic        ill64;
    } vec_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_ill;
    logic [6:0]  a_op, a_f7;
    logic [2:0]  a_f3, a_fmt;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [31:0] a_imm, a_pc;

    logic        b_in_ready, b_out_valid, b_ill;
    logic [6:0]  b_op, b_f7;
    logic [2:0]  b_f3, b_fmt;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [63:0] b_imm;
    logic [31:0] b_pc;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[12];
    exp_t q32[$];
    exp_t q64[$];
    logic [31:0] pc_ctr = 32'h1000;
    bit   saw_stall;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_opcode(a_op), .out_func3(a_f3), .out_func7(a_f7),
        .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
        .out_format(a_fmt), .out_imm(a_imm), .out_illegal(a_ill), .out_pc(a_pc)
    );

    decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_opcode(b_op), .out_func3(b_f3), .out_func7(b_f7),
        .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
        .out_format(b_fmt), .out_imm(b_imm), .out_illegal(b_ill), .out_pc(b_pc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_entry(input string tag, input exp_t e,
                             input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [2:0] fmt, input logic [63:0] imm, input logic ill,
                             input logic [31:0] pc);
        check({tag, "_fields"}, {32'h0, op, f3, f7, rd, rs1, rs2},
              {32'h0, e.inst[6:0], e.inst[14:12], e.inst[31:25],
               e.inst[11:7], e.inst[19:15], e.inst[24:20]});
        check({tag, "_format"}, {61'h0, fmt}, {61'h0, e.fmt});
        check({tag, "_imm"}, imm, e.imm);
        check({tag, "_illegal"}, {63'h0, ill}, {63'h0, e.ill});
        check({tag, "_pc"}, {32'h0, pc}, {32'h0, e.pc});
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.inst = vecs[idx].inst;
        e.pc   = pc_ctr;
        e.fmt  = vecs[idx].fmt32;
        e.imm  = {32'h0, vecs[idx].imm32};
        e.ill  = vecs[idx].ill32;
        q32.push_back(e);
        e.fmt  = vecs[idx].fmt64;
        e.imm  = vecs[idx].imm64;
        e.ill  = vecs[idx].ill64;
        q64.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input int idx, input bit no_stall);
        int waited = 0;
        bit done = 0;
        in_valid = 1'b1;
        in_inst  = vecs[idx].inst;
        in_pc    = pc_ctr;
        while (!done && waited < 50) begin
            if (a_in_ready) begin
                @(posedge clk);
                push_exp(idx);
                done = 1;
            end else begin
                @(posedge clk);
                waited++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        pc_ctr   = pc_ctr + 32'd4;
        if (waited > 0) saw_stall = 1;
        if (!done) check("send_timeout", {63'h0, done}, 64'h1);
        if (no_stall) check("no_stall", 64'(waited), 64'h0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30; i++) begin
            if (q32.size() == 0 && q64.size() == 0) break;
            @(negedge clk);
        end
        check(name, 64'(q32.size() + q64.size()), 64'h0);
    endtask

    // RV32 monitor: compare the presented entry against the queue head,
    // popping only when the entry actually transfers.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst && !flush && a_out_valid) begin
            if (q32.size() == 0) begin
                check("extra32", {63'h0, a_out_valid}, 64'h0);
            end else begin
                e = q32[0];
                cmp_entry("rv32", e, a_op, a_f3, a_f7, a_rd, a_rs1, a_rs2,
                          a_fmt, {32'h0, a_imm}, a_ill, a_pc);
                if (out_ready) void'(q32.pop_front());
            end
        end
    end

    // RV64 monitor.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst && !flush && b_out_valid) begin
            if (q64.size() == 0) begin
                check("extra64", {63'h0, b_out_valid}, 64'h0);
            end else begin
                e = q64[0];
                cmp_entry("rv64", e, b_op, b_f3, b_f7, b_rd, b_rs1, b_rs2,
                          b_fmt, b_imm, b_ill, b_pc);
                if (out_ready) void'(q64.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // inst, fmt32, imm32, ill32, fmt64, imm64, ill64
        vecs[0]  = '{32'hFFF10093, 3'd1, 32'hFFFFFFFF, 1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0}; // addi x1,x2,-1
        vecs[1]  = '{32'h123452B7, 3'd4, 32'h12345000, 1'b0, 3'd4, 64'h0000000012345000, 1'b0}; // lui x5,0x12345
        vecs[2]  = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // beq x0,x0,-4
        vecs[3]  = '{32'h00000000, 3'd7, 32'h00000000, 1'b1, 3'd7, 64'h0,                1'b1}; // all zero
        vecs[4]  = '{32'h002081BB, 3'd7, 32'h00000000, 1'b1, 3'd0, 64'h0,                1'b0}; // addw
        vecs[5]  = '{32'h00512423, 3'd2, 32'h00000008, 1'b0, 3'd2, 64'h8,                1'b0}; // sw x5,8(x2)
        vecs[6]  = '{32'hFE512E23, 3'd2, 32'hFFFFFFFC, 1'b0, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // sw x5,-4(x2)
        vecs[7]  = '{32'h001000EF, 3'd5, 32'h00000800, 1'b0, 3'd5, 64'h800,              1'b0}; // jal x1,0x800
        vecs[8]  = '{32'h002081B3, 3'd0, 32'h00000000, 1'b0, 3'd0, 64'h0,                1'b0}; // add
        vecs[9]  = '{32'h8000001B, 3'd7, 32'h00000000, 1'b1, 3'd1, 64'hFFFFFFFFFFFFF800, 1'b0}; // addiw -2048
        vecs[10] = '{32'hC0002573, 3'd1, 32'hFFFFFC00, 1'b0, 3'd1, 64'hFFFFFFFFFFFFFC00, 1'b0}; // csrrs
        vecs[11] = '{32'h80000517, 3'd4, 32'h80000000, 1'b0, 3'd4, 64'hFFFFFFFF80000000, 1'b0}; // auipc

        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b1; saw_stall = 0;

        // Reset state.
        #1;
        check("rst_out_valid32", {63'h0, a_out_valid}, 64'h0);
        check("rst_out_valid64", {63'h0, b_out_valid}, 64'h0);
        check("rst_format", {61'h0, a_fmt}, 64'h7);
        check("rst_imm", b_imm, 64'h0);
        check("rst_pc_rd", {27'h0, a_pc, a_rd}, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {62'h0, a_in_ready, b_in_ready}, 64'h3);
        @(negedge clk);

        // Single instruction: out_valid one cycle after acceptance.
        send(0, 1'b1);
        #1;
        check("latency", {63'h0, a_out_valid}, 64'h1);
        @(negedge clk);
        wait_drain("single_drained");

        // Back-to-back stream at full rate.
        for (int i = 0; i < 12; i++) send(i, 1'b1);
        wait_drain("burst_drained");

        // Eight instructions with downstream stalled for three cycles.
        repeat (3) @(negedge clk);
        saw_stall = 0;
        fork
            begin
                repeat (2) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) send(i, 1'b0);
        check("stall_in_ready_low", {63'h0, saw_stall}, 64'h1);
        wait_drain("stall_drained");
        repeat (2) @(negedge clk);

        // Flush while full with a simultaneous input.
        out_ready = 1'b0;
        send(1, 1'b0);
        send(2, 1'b0);
        check("full_in_ready", {63'h0, a_in_ready}, 64'h0);
        flush = 1'b1; in_valid = 1'b1; in_inst = vecs[3].inst; in_pc = 32'hDEAD0000;
        q32.delete(); q64.delete();
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_out_valid", {62'h0, a_out_valid, b_out_valid}, 64'h0);
        check("flush_in_ready", {63'h0, a_in_ready}, 64'h1);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        send(5, 1'b0);
        wait_drain("post_flush_drained");

        // Reset while full.
        out_ready = 1'b0;
        send(6, 1'b0);
        send(7, 1'b0);
        #3;
        rst = 1'b1;
        q32.delete(); q64.delete();
        #1;
        check("rst_full_out_valid", {62'h0, a_out_valid, b_out_valid}, 64'h0);
        check("rst_full_format", {61'h0, b_fmt}, 64'h7);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", {62'h0, a_in_ready, b_in_ready}, 64'h3);
        @(negedge clk);
        out_ready = 1'b1;
        send(9, 1'b1);
        wait_drain("post_rst_drained");
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
